softplus_inv_seq: RTL and testbench

SOFTPLUS_INV_SEQ -- requirements
Module: softplus_inv_seq

---
 rtl/softplus_inv_seq.sv | 178 +++++++++++++++++
 tb/tb_softplus_inv_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/softplus_inv_seq.sv
// softplus_inv_seq: piecewise-linear inverse-softplus estimator.
// A sample y is captured in IDLE, an 8-step scan over breakpoints x1..x8
// selects one of nine slices, then x = m(slice)*y + c(slice) is formed in
// two registered steps (MUL, ADD) and held until the consumer accepts it.
// All values are 32-bit sign-magnitude Q4.27 (1.0 = 0x08000000).
module softplus_inv_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] data_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] data_out,
    input  logic        cfg_we,
    input  logic [4:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEARCH = 3'd1,
        MUL    = 3'd2,
        ADD    = 3'd3,
        HOLD   = 3'd4
    } state_t;

    state_t      state_r;
    logic [31:0] coef_r [0:25];   // 0-8 m1..m9, 9-17 c1..c9, 18-25 x1..x8
    logic [31:0] y_r;
    logic [31:0] prod_r;
    logic [3:0]  slice_r;          // 1..9
    logic [2:0]  step_r;           // scan step 0..7 compares against x(step+1)
    logic [4:0]  m_idx_s;
    logic [4:0]  c_idx_s;
    logic [4:0]  x_idx_s;

    // Signed sign-magnitude a >= b; negative zero is treated as zero.
    function automatic logic sm_ge(input logic [31:0] a, input logic [31:0] b);
        logic a_neg;
        logic b_neg;
        a_neg = a[31] && (a[30:0] != 31'd0);
        b_neg = b[31] && (b[30:0] != 31'd0);
        if (a_neg != b_neg) begin
            sm_ge = !a_neg;
        end else if (!a_neg) begin
            sm_ge = (a[30:0] >= b[30:0]);
        end else begin
            sm_ge = (a[30:0] <= b[30:0]);
        end
    endfunction

    // Sign-magnitude fixed-point multiply, truncating, saturating magnitude.
    function automatic logic [31:0] sm_mul(input logic [31:0] a, input logic [31:0] b);
        logic [61:0] full;
        logic [34:0] scaled;
        logic [30:0] mag;
        full   = {31'd0, a[30:0]} * {31'd0, b[30:0]};
        scaled = full[61:27];
        if (scaled > 35'h07FFFFFFF) begin
            mag = 31'h7FFFFFFF;
        end else begin
            mag = scaled[30:0];
        end
        if (mag == 31'd0) begin
            sm_mul = 32'h00000000;
        end else begin
            sm_mul = {a[31] ^ b[31], mag};
        end
    endfunction

    // Sign-magnitude add with magnitude saturation; zero result is +0.
    function automatic logic [31:0] sm_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] sum;
        logic [30:0] mag;
        logic        sgn;
        sum = {1'b0, a[30:0]} + {1'b0, b[30:0]};
        if (a[31] == b[31]) begin
            mag = sum[31] ? 31'h7FFFFFFF : sum[30:0];
            sgn = a[31];
        end else if (a[30:0] > b[30:0]) begin
            mag = a[30:0] - b[30:0];
            sgn = a[31];
        end else if (b[30:0] > a[30:0]) begin
            mag = b[30:0] - a[30:0];
            sgn = b[31];
        end else begin
            mag = 31'd0;
            sgn = 1'b0;
        end
        if (mag == 31'd0) begin
            sm_add = 32'h00000000;
        end else begin
            sm_add = {sgn, mag};
        end
    endfunction

    // Handshake status decoded straight from the state register.
    always_comb begin
        in_ready = (state_r == IDLE);
        busy     = (state_r != IDLE);
    end

    // Coefficient-file addresses for the current slice and scan step.
    always_comb begin
        m_idx_s = 5'd0;
        c_idx_s = 5'd9;
        if ((slice_r >= 4'd1) && (slice_r <= 4'd9)) begin
            m_idx_s = {1'b0, slice_r} - 5'd1;
            c_idx_s = {1'b0, slice_r} + 5'd8;
        end else begin
            m_idx_s = 5'd0;
            c_idx_s = 5'd9;
        end
        x_idx_s = 5'd18 + {2'b00, step_r};
    end

    // Main sequencer: coefficient writes, scan, multiply, add, output hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            out_valid <= 1'b0;
            data_out  <= 32'h00000000;
            y_r       <= 32'h00000000;
            prod_r    <= 32'h00000000;
            slice_r   <= 4'd1;
            step_r    <= 3'd0;
            for (int i = 0; i < 26; i++) begin
                coef_r[i] <= 32'h00000000;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (cfg_we && (cfg_addr <= 5'd25)) begin
                        coef_r[cfg_addr] <= cfg_wdata;
                    end
                    if (in_valid) begin
                        y_r     <= data_in;
                        slice_r <= 4'd1;
                        step_r  <= 3'd0;
                        state_r <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (sm_ge(y_r, coef_r[x_idx_s])) begin
                        slice_r <= {1'b0, step_r} + 4'd2;
                    end
                    if (step_r == 3'd7) begin
                        state_r <= MUL;
                    end else begin
                        step_r <= step_r + 3'd1;
                    end
                end
                MUL: begin
                    prod_r  <= sm_mul(y_r, coef_r[m_idx_s]);
                    state_r <= ADD;
                end
                ADD: begin
                    data_out  <= sm_add(prod_r, coef_r[c_idx_s]);
                    out_valid <= 1'b1;
                    state_r   <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_softplus_inv_seq.sv
// Directed bench for softplus_inv_seq with hand-computed expected values.
module tb_softplus_inv_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] data_in = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] data_out;
    logic        cfg_we = 1'b0;
    logic [4:0]  cfg_addr = 5'd0;
    logic [31:0] cfg_wdata = 32'h0;
    logic        busy;

    int checks = 0;
    int errors = 0;

    softplus_inv_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [4:0] addr, input logic [31:0] data);
        cfg_we    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
    endtask

    task automatic start_sample(input string tag, input logic [31:0] y);
        check_eq({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        data_in  = y;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, input logic [31:0] exp);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check_eq({tag, "_lat"}, n, 32'd10);
        check_eq({tag, "_data"}, data_out, exp);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq({tag, "_vld_drop"}, {31'd0, out_valid}, 32'd0);
    endtask

    task automatic run(input string tag, input logic [31:0] y, input logic [31:0] exp);
        start_sample(tag, y);
        wait_out(tag, exp);
        handshake(tag);
    endtask

    initial begin
        logic [31:0] held;
        logic        saw_valid;

        #12;
        rst = 1'b0;
        tick();
        check_eq("rst_vld",  {31'd0, out_valid}, 32'd0);
        check_eq("rst_rdy",  {31'd0, in_ready},  32'd1);
        check_eq("rst_busy", {31'd0, busy},      32'd0);
        check_eq("rst_dout", data_out,           32'h00000000);

        // Zeroed coefficients give zero.
        run("zero", 32'h08000000, 32'h00000000);

        // Identity map: m=1.0, c=0, x=0.
        for (int k = 0; k < 9; k++) cfg_write(k[4:0], 32'h08000000);
        run("id_pos", 32'h18000000, 32'h18000000);
        run("id_neg", 32'h88000000, 32'h88000000);

        // m=0, ck=k.0, xk=k/8: output reveals the chosen slice.
        for (int k = 1; k <= 9; k++) begin
            cfg_write(k[4:0] - 5'd1, 32'h00000000);
            cfg_write(k[4:0] + 5'd8, k << 27);
        end
        for (int k = 1; k <= 8; k++) cfg_write(k[4:0] + 5'd17, k << 24);
        run("sl_eq_x4",  32'h04000000, 32'h28000000);
        run("sl_bel_x4", 32'h03FFFFFF, 32'h20000000);
        run("sl_neg",    32'h80000001, 32'h08000000);
        run("sl_top",    32'h7FFFFFFF, 32'h48000000);
        run("sl_negz",   32'h80000000, 32'h08000000);

        // Multiply saturation, then exact cancellation in the adder.
        pulse_reset();
        cfg_write(5'd8, 32'h78000000);
        run("sat", 32'h20000000, 32'h7FFFFFFF);
        cfg_write(5'd8,  32'h88000000);
        cfg_write(5'd17, 32'h08000000);
        run("cancel", 32'h08000000, 32'h00000000);

        // Output held while consumer stalls; writes and inputs ignored.
        cfg_write(5'd17, 32'h10000000);
        start_sample("hold", 32'h08000000);
        wait_out("hold", 32'h08000000);
        held = data_out;
        for (int i = 0; i < 5; i++) begin
            cfg_we    = 1'b1;
            cfg_addr  = 5'd0;
            cfg_wdata = 32'h08000000;
            in_valid  = 1'b1;
            data_in   = 32'h18000000;
            tick();
            check_eq("hold_vld",  {31'd0, out_valid}, 32'd1);
            check_eq("hold_dout", data_out, held);
            check_eq("hold_rdy",  {31'd0, in_ready}, 32'd0);
            check_eq("hold_busy", {31'd0, busy}, 32'd1);
        end
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        handshake("hold");
        check_eq("retain", data_out, 32'h08000000);
        run("wr_drop", 32'h88000000, 32'h00000000);

        // Reset during SEARCH aborts without an output pulse.
        cfg_write(5'd8, 32'h08000000);
        start_sample("abort", 32'h08000000);
        tick();
        tick();
        tick();
        check_eq("abort_busy", {31'd0, busy}, 32'd1);
        pulse_reset();
        saw_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) saw_valid = 1'b1;
        end
        check_eq("abort_novld", {31'd0, saw_valid}, 32'd0);
        check_eq("abort_rdy",   {31'd0, in_ready},  32'd1);
        run("post_abort", 32'h08000000, 32'h00000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
